// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and latency
// counter sizing shared by the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_t;

  typedef enum logic {
    MDU_STATE_IDLE = 1'b0,
    MDU_STATE_RUN  = 1'b1
  } mdu_state_t;

  function automatic int mdu_cnt_w(
    input int lat_a,
    input int lat_b
  );
    int m;
    m = (lat_a > lat_b) ? lat_a : lat_b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: combinational signed/unsigned divide
// with defined div-by-zero and overflow results.
import mdu_pkg::*;

module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  // magnitude divide, then restore signs; corner cases override
  always_comb begin
    neg_a = is_signed & a[WIDTH-1];
    neg_b = is_signed & b[WIDTH-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
    if (mag_b == '0) mag_b = {{(WIDTH-1){1'b0}}, 1'b1};
    uq  = mag_a / mag_b;
    ur  = mag_a % mag_b;
    quo = (neg_a ^ neg_b) ? -uq : uq;
    rem = neg_a ? -ur : ur;
    if (b == '0) begin
      quo = '1;
      rem = a;
    end else if (is_signed && a == MIN_NEG && b == '1) begin
      quo = a;
      rem = '0;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide with HI/LO.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
import mdu_pkg::*;

module mdu_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = mdu_cnt_w(MUL_LAT, DIV_LAT);
  localparam int W2 = 2 * WIDTH;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  mdu_state_t      state;
  mdu_state_t      state_nxt;
  logic [CW-1:0]   cnt;
  logic [W2-1:0]   pend;
  logic [W2-1:0]   pend_nxt;
  logic [W2-1:0]   prod_s;
  logic [W2-1:0]   prod_u;
  logic [W2-1:0]   hilo;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic            is_long;
  logic            use_div;
  logic            wr_hi;
  logic            wr_lo;
  logic            accept;
  logic            commit;

  assign hilo   = {hi, lo};
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} *
                  {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} *
                  {{WIDTH{1'b0}}, b};
  assign accept = (state == MDU_STATE_IDLE) & start & ~flush;
  assign commit = (state == MDU_STATE_RUN) & ~flush &
                  (cnt == '0);
  assign busy   = (state == MDU_STATE_RUN);

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .is_signed (op == MDU_DIV),
    .a         (a),
    .b         (b),
    .quo       (quo),
    .rem       (rem)
  );

  // op decode: pending result and write/latency selects
  always_comb begin
    is_long  = 1'b0;
    use_div  = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    pend_nxt = pend;
    unique case (1'b1)
      (op == MDU_MULT): begin
        is_long  = 1'b1;
        pend_nxt = prod_s;
      end
      (op == MDU_MULTU): begin
        is_long  = 1'b1;
        pend_nxt = prod_u;
      end
      (op == MDU_DIV),
      (op == MDU_DIVU): begin
        is_long  = 1'b1;
        use_div  = 1'b1;
        pend_nxt = {rem, quo};
      end
      (op == MDU_MTHI): wr_hi = 1'b1;
      (op == MDU_MTLO): wr_lo = 1'b1;
`ifdef MDU_MADD_EN
      (op == MDU_MADD): begin
        is_long  = 1'b1;
        pend_nxt = hilo + prod_s;
      end
      (op == MDU_MADDU): begin
        is_long  = 1'b1;
        pend_nxt = hilo + prod_u;
      end
      (op == MDU_MSUB): begin
        is_long  = 1'b1;
        pend_nxt = hilo - prod_s;
      end
      (op == MDU_MSUBU): begin
        is_long  = 1'b1;
        pend_nxt = hilo - prod_u;
      end
`endif
      default: ;
    endcase
  end

  // next-state: RUN while counting, flush or count end exits
  always_comb begin
    state_nxt = state;
    unique case (state)
      MDU_STATE_IDLE:
        if (accept && is_long) state_nxt = MDU_STATE_RUN;
      MDU_STATE_RUN:
        if (flush || cnt == '0) state_nxt = MDU_STATE_IDLE;
      default: state_nxt = MDU_STATE_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MDU_STATE_IDLE;
    else        state <= state_nxt;
  end

  // latency counter and operand-time result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      pend <= '0;
    end else if (accept && is_long) begin
      cnt  <= use_div ? DIV_LOAD : MUL_LOAD;
      pend <= pend_nxt;
    end else if (state == MDU_STATE_RUN) begin
      cnt  <= (flush || cnt == '0) ? '0 : cnt - 1'b1;
    end
  end

  // HI/LO update on commit or direct move
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= pend[W2-1:WIDTH];
      lo <= pend[WIDTH-1:0];
    end else if (accept && wr_hi) begin
      hi <= a;
    end else if (accept && wr_lo) begin
      lo <= a;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized self-checking bench for
// mdu_unit against a 64-bit arithmetic reference.
module tb_mdu_unit;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  int n_checks = 0;
  int n_pass = 0;

  mdu_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "timeout");
  end

  function automatic int model(input logic [3:0] o,
                               input logic [W-1:0] x,
                               input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] acc, p;
    int lat;
    lat = 0;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    acc = {exp_hi, exp_lo};
    case (o)
      4'd1: begin p = sx * sy; {exp_hi, exp_lo} = p; lat = ML; end
      4'd2: begin
        p = {32'd0, x} * {32'd0, y};
        {exp_hi, exp_lo} = p; lat = ML;
      end
      4'd3, 4'd4: begin
        lat = DL;
        if (y == 0) begin exp_lo = '1; exp_hi = x; end
        else if (o == 4'd3) begin
          q = sx / sy; r = sx % sy;
          exp_lo = q[31:0]; exp_hi = r[31:0];
        end else begin
          exp_lo = x / y; exp_hi = x % y;
        end
      end
      4'd5: exp_hi = x;
      4'd6: exp_lo = x;
`ifdef MDU_MADD_EN
      4'd7: begin p = sx * sy; {exp_hi, exp_lo} = acc + p; lat = ML; end
      4'd8: begin
        p = {32'd0, x} * {32'd0, y};
        {exp_hi, exp_lo} = acc + p; lat = ML;
      end
      4'd9: begin p = sx * sy; {exp_hi, exp_lo} = acc - p; lat = ML; end
      4'd10: begin
        p = {32'd0, x} * {32'd0, y};
        {exp_hi, exp_lo} = acc - p; lat = ML;
      end
`endif
      default: lat = 0;
    endcase
    return lat;
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b0; start = 1'b1; op = OP_MULT;
    a = 32'hFFFF_FFFD; b = 32'd7;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if ({hi, lo} !== 64'd0) $display("FAIL rst_hilo: got %h want 0", {hi, lo});
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    n_checks++;
    if (cyc != ML) $display("FAIL rst_mult_lat: got %0d want %0d", cyc, ML);
    else n_pass++;
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB)
      $display("FAIL rst_mult: got %h_%h want ffffffff_ffffffeb", hi, lo);
    else n_pass++;
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
  endtask

  task automatic check_op(input string nm, input logic [3:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y);
    int cyc, lat;
    lat = model(o, x, y);
    run_op(o, x, y, cyc);
    n_checks++;
    if (cyc != lat) $display("FAIL %s_lat: got %0d want %0d", nm, cyc, lat);
    else n_pass++;
    n_checks++;
    if (hi !== exp_hi || lo !== exp_lo)
      $display("FAIL %s op=%0d a=%h b=%h: got %h_%h want %h_%h",
               nm, o, x, y, hi, lo, exp_hi, exp_lo);
    else n_pass++;
  endtask

  task automatic test_mult();
    check_op("mult_fix", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    for (int i = 0; i < 6; i++)
      check_op("mult_rnd", (i % 2 == 0) ? OP_MULT : OP_MULTU,
               $urandom, $urandom);
  endtask

  task automatic test_div();
    check_op("div_fix", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
      $display("FAIL div_neg7_2: got %h_%h want ffffffff_fffffffd", hi, lo);
    else n_pass++;
    check_op("divu_zero", OP_DIVU, 32'd7, 32'd0);
    n_checks++;
    if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF)
      $display("FAIL divu_7_0: got %h_%h want 00000007_ffffffff", hi, lo);
    else n_pass++;
    check_op("div_zero", OP_DIV, 32'h8000_0011, 32'd0);
    check_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000)
      $display("FAIL div_ovf_const: got %h_%h want 00000000_80000000", hi, lo);
    else n_pass++;
    for (int i = 0; i < 8; i++)
      check_op("div_rnd", (i % 2 == 0) ? OP_DIV : OP_DIVU, $urandom,
               ($urandom_range(0, 3) == 0) ? 32'd0 :
               (i < 4 ? $urandom : 32'($urandom_range(1, 300))));
  endtask

  task automatic test_mthi();
    check_op("mthi", OP_MTHI, 32'h1234, 32'd0);
    n_checks++;
    if (hi !== 32'h1234) $display("FAIL mthi_val: got %h want 00001234", hi);
    else n_pass++;
    check_op("mtlo", OP_MTLO, $urandom, 32'd0);
  endtask

  task automatic test_flush();
    int lat;
    logic [W-1:0] old_hi, old_lo;
    old_hi = hi; old_lo = lo;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1; start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
    @(negedge clk);
    flush = 1'b0; start = 1'b0; op = OP_NOP;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hi !== old_hi || lo !== old_lo)
      $display("FAIL flush_keep: got %b %h_%h want 0 %h_%h",
               busy, hi, lo, old_hi, old_lo);
    else n_pass++;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (ML - 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== old_hi || lo !== old_lo)
      $display("FAIL flush_commit: got %b %h_%h want 0 %h_%h",
               busy, hi, lo, old_hi, old_lo);
    else n_pass++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    lat = 0;
    check_op("post_flush", OP_MULTU, $urandom, $urandom);
  endtask

  task automatic test_back_to_back();
    int cyc, lat;
    logic [3:0] o;
    lat = model(OP_DIVU, 32'd100, 32'd3);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1) break;
      cyc++;
      if (i == 1) begin start = 1'b1; op = OP_MTHI; a = 32'hDEAD; end
      else if (i == 2) begin op = OP_MULT; a = 32'd3; b = 32'd3; end
      else if (i == 3) begin start = 1'b0; op = OP_NOP; end
      @(negedge clk);
    end
    n_checks++;
    if (cyc != lat) $display("FAIL b2b_lat: got %0d want %0d", cyc, lat);
    else n_pass++;
    n_checks++;
    if (hi !== exp_hi || lo !== exp_lo)
      $display("FAIL b2b_ignore: got %h_%h want %h_%h",
               hi, lo, exp_hi, exp_lo);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      o = 4'($urandom_range(0, 15));
      check_op("rnd_seq", o, $urandom,
               ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom);
    end
  endtask

  task automatic test_madd();
    int cyc;
    check_op("madd_sethi", OP_MTHI, 32'd0, 32'd0);
    check_op("madd_setlo", OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    void'(model(OP_MADDU, 32'd1, 32'd1));
    run_op(OP_MADDU, 32'd1, 32'd1, cyc);
`ifdef MDU_MADD_EN
    n_checks++;
    if (cyc != ML || hi !== 32'd1 || lo !== 32'd0)
      $display("FAIL maddu: got lat %0d %h_%h want %0d 00000001_00000000",
               cyc, hi, lo, ML);
    else n_pass++;
`else
    n_checks++;
    if (cyc != 0 || hi !== 32'd0 || lo !== 32'hFFFF_FFFF)
      $display("FAIL maddu_off: got lat %0d %h_%h want 0 00000000_ffffffff",
               cyc, hi, lo);
    else n_pass++;
`endif
    for (int i = 0; i < 8; i++)
      check_op("madd_rnd", 4'(7 + (i % 4)), $urandom, $urandom);
  endtask

  task automatic test_reset_mid();
    check_op("pre_rst", OP_MTHI, 32'h55, 32'd0);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = $urandom; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || {hi, lo} !== 64'd0)
      $display("FAIL rst_mid: got %b %h_%h want 0 0", busy, hi, lo);
    else n_pass++;
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (DL + 2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || {hi, lo} !== 64'd0)
      $display("FAIL rst_mid_after: got %b %h_%h want 0 0", busy, hi, lo);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi();
    test_flush();
    test_back_to_back();
    test_madd();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
